// File: rtl/nco_pkg.sv
// -----------------------------------------------------------------------------
// nco_pkg
// Shared definitions for the quarter-wave sine/cosine NCO:
//   quad_t       - 2-bit phase quadrant (Q0..Q3)
//   NCO_LATENCY  - cycles from an accepted strobe to its out_valid
//   qsin_entry() - elaboration-time quarter-wave table entry generator
// -----------------------------------------------------------------------------
package nco_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  localparam int unsigned NCO_LATENCY = 3;

  // pi in Q30 fixed point
  localparam longint PI_Q30 = 64'sd3373259426;

  // round(scale * sin(pi*(2i+1) / (4*2**abits))), evaluated with an integer
  // Taylor series in Q30 so it folds to a constant during elaboration.
  // The argument is at most pi/2, so every product stays below 2**63.
  function automatic longint qsin_entry(input int i, input int abits, input longint scale);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (PI_Q30 * longint'(2 * i + 1)) >>> (abits + 2);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 12; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return (sum * scale + (64'sd1 <<< 29)) >>> 30;
  endfunction

endpackage

// File: rtl/qsin_rom.sv
// -----------------------------------------------------------------------------
// qsin_rom
// Quarter-wave magnitude table with two registered read ports (one for the
// sine path, one for the cosine path). Contents fixed at elaboration.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset (clears read data)
//   rd_en           - capture new read data this cycle
//   addr_s, addr_c  - ABITS-bit table addresses
//   data_s, data_c  - DW-bit unsigned magnitudes, one cycle after the address
// -----------------------------------------------------------------------------
module qsin_rom
  import nco_pkg::*;
#(
  parameter int DW    = 16,
  parameter int ABITS = 8,
  parameter int SCALE = 2**(DW-1) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [ABITS-1:0] addr_s,
  input  logic [ABITS-1:0] addr_c,
  output logic [DW-1:0]    data_s,
  output logic [DW-1:0]    data_c
);

  localparam int SIZE = 2**ABITS;

  logic [DW-1:0] table_mem [SIZE];

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_tbl
    localparam logic [DW-1:0] ENTRY = DW'(qsin_entry(gi, ABITS, longint'(SCALE)));
    assign table_mem[gi] = ENTRY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_s <= '0;
      data_c <= '0;
    end else if (rd_en) begin
      data_s <= table_mem[addr_s];
      data_c <= table_mem[addr_c];
    end
  end

endmodule

// File: rtl/qsin_nco.sv
// -----------------------------------------------------------------------------
// qsin_nco
// Phase-accumulator NCO producing registered signed sine and cosine samples
// from a quarter-wave table. Three-stage pipeline: S0 quadrant/index capture,
// S1 table read, S2 sign application.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   en            - sample strobe: emit one sample, advance the phase
//   load          - load phase_init into the accumulator (wins over advance)
//   phase_init    - accumulator load value (PW bits)
//   phase_inc     - per-sample phase step (PW bits, modulo 2**PW)
//   phase_off     - static offset added to the accumulator before lookup
//   sin_out       - signed DW-bit sine sample (holds between samples)
//   cos_out       - signed DW-bit cosine sample (holds between samples)
//   out_valid     - one-cycle flag per new sample, 3 cycles after the strobe
// -----------------------------------------------------------------------------
module qsin_nco
  import nco_pkg::*;
#(
  parameter int DW    = 16,
  parameter int ABITS = 8,
  parameter int PW    = 24,
  parameter int SCALE = 2**(DW-1) - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [PW-1:0]        phase_init,
  input  logic [PW-1:0]        phase_inc,
  input  logic [PW-1:0]        phase_off,
  output logic signed [DW-1:0] sin_out,
  output logic signed [DW-1:0] cos_out,
  output logic                 out_valid
);

  // Phase bits below the table index are truncated
  localparam int LOW = PW - 2 - ABITS;

  logic [PW-1:0]    acc_q, acc_d;
  logic [ABITS+1:0] look_w;          // {quadrant, index} of acc + phase_off
  quad_t            quad_w;
  logic [ABITS-1:0] idx_w;

  // Only the top ABITS+2 bits of the sum are needed; the truncated low bits
  // matter solely through their carry: a + b overflows L bits iff a > ~b.
  if (LOW > 0) begin : g_carry
    logic carry_w;
    assign carry_w = (acc_q[LOW-1:0] > ~phase_off[LOW-1:0]);
    assign look_w  = acc_q[PW-1 -: ABITS+2] + phase_off[PW-1 -: ABITS+2]
                   + {{(ABITS+1){1'b0}}, carry_w};
  end else begin : g_nocarry
    assign look_w = acc_q + phase_off;
  end

  assign quad_w = quad_t'(look_w[ABITS+1:ABITS]);
  assign idx_w  = look_w[ABITS-1:0];

  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = phase_init;
    end else if (en) begin
      acc_d = acc_q + phase_inc;
    end
  end

  // S0: accumulator plus captured quadrant/index of the strobed phase
  quad_t            quad_s0_q;
  logic [ABITS-1:0] idx_s0_q;
  logic             vld_s0_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      quad_s0_q <= Q0;
      idx_s0_q  <= '0;
      vld_s0_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      vld_s0_q <= en;
      if (en) begin
        quad_s0_q <= quad_w;
        idx_s0_q  <= idx_w;
      end
    end
  end

  // Cosine is the sine of the next quadrant with the same index. Odd
  // quadrants read the table mirrored, upper quadrants negate.
  quad_t            cos_quad_w;
  logic [ABITS-1:0] addr_s_w, addr_c_w;
  logic [DW-1:0]    mag_s_w, mag_c_w;

  assign cos_quad_w = quad_t'(quad_s0_q + 2'd1);
  assign addr_s_w   = quad_s0_q[0]  ? ~idx_s0_q : idx_s0_q;
  assign addr_c_w   = cos_quad_w[0] ? ~idx_s0_q : idx_s0_q;

  qsin_rom #(
    .DW    (DW),
    .ABITS (ABITS),
    .SCALE (SCALE)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (vld_s0_q),
    .addr_s (addr_s_w),
    .addr_c (addr_c_w),
    .data_s (mag_s_w),
    .data_c (mag_c_w)
  );

  // S1: sign flags travel alongside the table read
  logic neg_s_s1_q, neg_c_s1_q, vld_s1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_s_s1_q <= 1'b0;
      neg_c_s1_q <= 1'b0;
      vld_s1_q   <= 1'b0;
    end else begin
      vld_s1_q <= vld_s0_q;
      if (vld_s0_q) begin
        neg_s_s1_q <= quad_s0_q[1];
        neg_c_s1_q <= cos_quad_w[1];
      end
    end
  end

  // S2: apply sign; SCALE <= 2**(DW-1)-1 so negation cannot overflow
  logic [DW-1:0] sin_d, cos_d;

  always_comb begin
    sin_d = neg_s_s1_q ? -mag_s_w : mag_s_w;
    cos_d = neg_c_s1_q ? -mag_c_w : mag_c_w;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sin_out   <= '0;
      cos_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_s1_q;
      if (vld_s1_q) begin
        sin_out <= $signed(sin_d);
        cos_out <= $signed(cos_d);
      end
    end
  end

endmodule

// File: tb/tb_qsin_nco.sv
// -----------------------------------------------------------------------------
// tb_qsin_nco
// Directed bench for qsin_nco (DW=16, ABITS=8, PW=24, SCALE=32767).
// Expected samples are hand-derived from the quarter-wave table:
//   T[0] = round(32767*sin(pi/1024)) = 101, T[255] = 32767.
// -----------------------------------------------------------------------------
module tb_qsin_nco;
  import nco_pkg::*;

  localparam int DW    = 16;
  localparam int ABITS = 8;
  localparam int PW    = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 load;
  logic [PW-1:0]        phase_init;
  logic [PW-1:0]        phase_inc;
  logic [PW-1:0]        phase_off;
  logic signed [DW-1:0] sin_out;
  logic signed [DW-1:0] cos_out;
  logic                 out_valid;

  int checks   = 0;
  int failures = 0;

  int exp_s [4] = '{101, 32767, -101, -32767};
  int exp_c [4] = '{32767, -101, -32767, 101};

  always #5 clk = ~clk;

  qsin_nco #(
    .DW    (DW),
    .ABITS (ABITS),
    .PW    (PW),
    .SCALE (32767)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .phase_init (phase_init),
    .phase_inc  (phase_inc),
    .phase_off  (phase_off),
    .sin_out    (sin_out),
    .cos_out    (cos_out),
    .out_valid  (out_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int s, input int c);
    chk({tag, "_valid"}, {31'd0, out_valid}, v);
    chk({tag, "_sin"}, sin_out, s);
    chk({tag, "_cos"}, cos_out, c);
  endtask

  initial begin
    rst        = 1'b0;
    en         = 1'b0;
    load       = 1'b0;
    phase_init = '0;
    phase_inc  = '0;
    phase_off  = '0;
    step();
    step();
    chk_out("reset", 0, 0, 0);
    rst = 1'b1;
    step();

    // Phase 0, single strobe
    en = 1'b1;
    step();
    en = 1'b0;
    chk("p0_lat0_valid", {31'd0, out_valid}, 0);
    for (int k = 1; k < NCO_LATENCY - 1; k++) begin
      step();
      chk($sformatf("p0_lat%0d_valid", k), {31'd0, out_valid}, 0);
    end
    step();
    chk_out("p0", 1, 101, 32767);
    step();
    chk_out("p0_hold", 0, 101, 32767);

    // Quarter-turn steps, continuous strobes
    load       = 1'b1;
    phase_init = '0;
    step();
    load      = 1'b0;
    phase_inc = 24'h400000;
    for (int i = 0; i < 10; i++) begin
      en = (i < 8);
      step();
      if (i >= 2)
        chk_out($sformatf("cont%0d", i - 2), 1, exp_s[(i-2)%4], exp_c[(i-2)%4]);
      else
        chk($sformatf("cont_fill%0d_valid", i), {31'd0, out_valid}, 0);
    end
    step();
    chk("cont_end_valid", {31'd0, out_valid}, 0);

    // Load and strobe in the same cycle
    phase_inc  = '0;
    load       = 1'b1;
    phase_init = '0;
    step();
    en         = 1'b1;
    phase_init = 24'h800000;
    step();
    load = 1'b0;
    step();
    en = 1'b0;
    step();
    chk_out("ld_first", 1, 101, 32767);
    step();
    chk_out("ld_second", 1, -101, -32767);

    // Accumulator wrap from all-ones
    load       = 1'b1;
    phase_init = 24'hFFFFFF;
    phase_inc  = 24'h000001;
    step();
    load = 1'b0;
    en   = 1'b1;
    step();
    step();
    en = 1'b0;
    step();
    chk_out("wrap_first", 1, -101, 32767);
    step();
    chk_out("wrap_second", 1, 101, 32767);
    step();
    chk("wrap_end_valid", {31'd0, out_valid}, 0);

    // Static phase offset of a quarter turn
    load       = 1'b1;
    phase_init = '0;
    phase_inc  = '0;
    phase_off  = 24'h400000;
    step();
    load = 1'b0;
    en   = 1'b1;
    step();
    en = 1'b0;
    step();
    step();
    chk_out("offset", 1, 32767, -101);
    phase_off = '0;

    // Reset in the middle of a running stream
    load       = 1'b1;
    phase_init = 24'h400000;
    phase_inc  = 24'h400000;
    step();
    load = 1'b0;
    en   = 1'b1;
    step();
    step();
    step();
    chk("pre_rst_valid", {31'd0, out_valid}, 1);
    rst = 1'b0;
    #2;
    chk_out("rst_async", 0, 0, 0);
    step();
    step();
    chk_out("rst_held", 0, 0, 0);
    rst = 1'b1;
    step();
    chk("post_rst_lat0_valid", {31'd0, out_valid}, 0);
    step();
    chk("post_rst_lat1_valid", {31'd0, out_valid}, 0);
    step();
    chk_out("post_rst_s0", 1, 101, 32767);
    en = 1'b0;
    step();
    chk_out("post_rst_s1", 1, 32767, -101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qsin_nco.md
QSIN_NCO -- requirements
Module: qsin_nco

Interface
REQ-001 SHALL have parameter DW, default 16, meaning output sample width (signed two's complement).
REQ-002 SHALL have parameter ABITS, default 8, meaning quarter-wave table address bits (SIZE = 2**ABITS entries).
REQ-003 SHALL have parameter PW, default 24, meaning phase accumulator width; PW >= ABITS+2.
REQ-004 SHALL have parameter SCALE, default 2**(DW-1)-1, meaning peak magnitude; SCALE <= 2**(DW-1)-1.
REQ-005 SHALL have port clk  input  1  meaning the single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  meaning reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  meaning sample strobe: emit one sample and advance phase.
REQ-008 SHALL have port load  input  1  meaning load phase_init into the accumulator.
REQ-009 SHALL have port phase_init  input  PW  meaning accumulator load value.
REQ-010 SHALL have port phase_inc  input  PW  meaning per-sample phase step (unsigned, modulo 2**PW).
REQ-011 SHALL have port phase_off  input  PW  meaning static phase offset added before lookup.
REQ-012 SHALL have port sin_out  output  DW  meaning registered signed sine sample.
REQ-013 SHALL have port cos_out  output  DW  meaning registered signed cosine sample.
REQ-014 SHALL have port out_valid  output  1  meaning sin_out/cos_out carry a new sample this cycle.

Function
REQ-015 SHALL hold accumulator acc (PW bits); load=1: acc <= phase_init; else en=1: acc <= acc + phase_inc (wraps mod 2**PW); else hold.
REQ-016 SHALL, when load and en are both 1, load phase_init and still emit a sample from the pre-load acc value.
REQ-017 SHALL form lookup phase p = acc + phase_off (mod 2**PW) from the acc value present in the cycle en is sampled.
REQ-018 SHALL take quadrant q = p[PW-1:PW-2], index idx = p[PW-3:PW-2-ABITS]; lower bits are truncated, no interpolation.
REQ-019 SHALL use table T[i] = round(SCALE*sin(2*pi*(i+0.5)/(4*SIZE))), unsigned magnitude, i = 0..SIZE-1, fixed at elaboration.
REQ-020 SHALL compute sine: q=0 -> +T[idx]; q=1 -> +T[SIZE-1-idx]; q=2 -> -T[idx]; q=3 -> -T[SIZE-1-idx].
REQ-021 SHALL compute cosine with the same rule using quadrant (q+1) mod 4 and the same idx.
REQ-022 SHALL perform negation in DW bits; no overflow possible given REQ-004.
REQ-023 SHALL pipeline 3 stages: S0 register q/idx/valid, S1 table read (two read ports, sine and cosine), S2 sign apply into outputs.
REQ-024 SHALL assert out_valid exactly 3 cycles after each cycle with en=1, one cycle per strobe; back-to-back strobes give back-to-back samples.
REQ-025 SHALL hold sin_out/cos_out at last value while out_valid=0.
REQ-026 SHALL not stall; no backpressure; phase_inc/phase_off changes take effect at the next en.

Reset
REQ-027 SHALL on rst=0 asynchronously clear acc, all pipeline registers, sin_out, cos_out, out_valid to 0.
REQ-028 SHALL discard in-flight samples on reset; first out_valid after release is 3 cycles after first en.

Structure
REQ-029 SHALL place quadrant type (2-bit enum Q0..Q3) and pipeline latency constant (3) in shared package nco_pkg.
REQ-030 SHALL instantiate one sub-module qsin_rom: dual-read-port registered quarter-wave table with parameters DW, ABITS, SCALE.

Verification (DW=16, ABITS=8, PW=24, SCALE=32767)
REQ-031 SHALL check reset: rst=0 mid-stream -> outputs 0, out_valid 0 immediately, no valid for 3 cycles after first en post-release.
REQ-032 SHALL check phase 0, single en -> 3 cycles later sin_out=101, cos_out=32767, out_valid one cycle.
REQ-033 SHALL check phase_inc=0x400000 continuous en -> sin 101,32767,-101,-32767 repeating; cos 32767,-101,-32767,101.
REQ-034 SHALL check load+en same cycle with phase_init=0x800000 from acc=0 -> sample sin=101, next sample sin=-101 (phase_inc=0).
REQ-035 SHALL check wrap: acc=0xFFFFFF, phase_inc=1, two en -> second sample sin=101 (phase 0), no glitch.
REQ-036 SHALL check phase_off=0x400000, acc=0 -> sin_out equals cos_out of offset 0 (32767).
